// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller: state encoding, parity codes and
// payload width.
package uart_pkg;

  localparam int unsigned DataWidth = 8;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSync   = 3'd1;
  localparam logic [2:0] StStart  = 3'd2;
  localparam logic [2:0] StData   = 3'd3;
  localparam logic [2:0] StParity = 3'd4;
  localparam logic [2:0] StStop   = 3'd5;
  localparam logic [2:0] StGap    = 3'd6;

  localparam logic [1:0] NONE0 = 2'b00;
  localparam logic [1:0] ODD   = 2'b01;
  localparam logic [1:0] EVEN  = 2'b10;
  localparam logic [1:0] NONE3 = 2'b11;

  function automatic logic parity_enabled(logic [1:0] parity_type);
    return (parity_type == ODD) || (parity_type == EVEN);
  endfunction

endpackage

// File: rtl/uart_parity.sv
// Combinational parity generator for one payload byte; drives 0 while reset is high or
// parity is disabled.
module uart_parity
  import uart_pkg::*;
(
  input  logic                 reset,
  input  logic [DataWidth-1:0] data_in,
  input  logic [1:0]           parity_type,
  output logic                 parity_bit
);

  logic xor_all;

  assign xor_all = ^data_in;

  always_comb begin
    parity_bit = 1'b0;
    if (!reset) begin
      case (parity_type)
        EVEN:    parity_bit = xor_all;
        ODD:     parity_bit = ~xor_all;
        default: parity_bit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame transmitter: start bit, 8 data bits LSB first, optional parity, one or two
// stop bits and an optional idle gap, all paced by an external baud strobe.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FRAME_GAP = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DataWidth-1:0] data_in,
  input  logic [1:0]           parity_type,
  input  logic                 stop2,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [3:0] GapLast = 4'(FRAME_GAP - 1);

  logic [2:0]           state_q, state_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [1:0]           ptype_q, ptype_d;
  logic                 stop2_q, stop2_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic                 frame_end;
  logic                 parity_bit;

  uart_parity u_parity (
    .reset       (reset),
    .data_in     (data_q),
    .parity_type (ptype_q),
    .parity_bit  (parity_bit)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    ptype_d    = ptype_q;
    stop2_d    = stop2_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    frame_end  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d    = StSync;
          data_d     = data_in;
          ptype_d    = parity_type;
          stop2_d    = stop2;
          bit_idx_d  = 3'd0;
          stop_cnt_d = 1'b0;
          gap_cnt_d  = 4'd0;
        end
      end
      // SYNC waits for a tick boundary so the start bit spans a whole bit period.
      StSync: begin
        if (baud_tick) state_d = StStart;
      end
      StStart: begin
        if (baud_tick) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (baud_tick) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d    = parity_enabled(ptype_q) ? StParity : StStop;
            stop_cnt_d = 1'b0;
          end
        end
      end
      StParity: begin
        if (baud_tick) begin
          state_d    = StStop;
          stop_cnt_d = 1'b0;
        end
      end
      StStop: begin
        if (baud_tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            frame_end  = 1'b1;
            stop_cnt_d = 1'b0;
            gap_cnt_d  = 4'd0;
            state_d    = (FRAME_GAP == 0) ? StIdle : StGap;
          end
        end
      end
      StGap: begin
        if (baud_tick) begin
          if (gap_cnt_q == GapLast) begin
            state_d   = StIdle;
            gap_cnt_d = 4'd0;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      ptype_q    <= '0;
      stop2_q    <= 1'b0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      ptype_q    <= ptype_d;
      stop2_q    <= stop2_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    tx_out = 1'b1;
    case (state_q)
      StStart:  tx_out = 1'b0;
      StData:   tx_out = data_q[bit_idx_q];
      StParity: tx_out = parity_bit;
      default:  tx_out = 1'b1;
    endcase
  end

  assign tx_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign done     = frame_end & ~reset;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: known frames, random frames against a bit-list model, and
// hand-written reset, gap and tick-alignment sequences.
module tb_uart_tx_ctrl;

  logic       clk;
  logic       reset;
  logic       baud_tick;
  logic       tx_valid;
  logic       sel;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic       stop2;
  logic       tick_en;

  logic tx_valid0, tx_valid2;
  logic ready0, out0, busy0, done0;
  logic ready2, out2, busy2, done2;
  logic tx_ready_s, tx_out_s, busy_s, done_s;

  int n_pass;
  int n_total;

  assign tx_valid0  = tx_valid & ~sel;
  assign tx_valid2  = tx_valid & sel;
  assign tx_ready_s = sel ? ready2 : ready0;
  assign tx_out_s   = sel ? out2 : out0;
  assign busy_s     = sel ? busy2 : busy0;
  assign done_s     = sel ? done2 : done0;

  uart_tx_ctrl #(.FRAME_GAP(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .tx_valid    (tx_valid0),
    .tx_ready    (ready0),
    .data_in     (data_in),
    .parity_type (parity_type),
    .stop2       (stop2),
    .tx_out      (out0),
    .busy        (busy0),
    .done        (done0)
  );

  uart_tx_ctrl #(.FRAME_GAP(2)) dut_gap (
    .clk         (clk),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .tx_valid    (tx_valid2),
    .tx_ready    (ready2),
    .data_in     (data_in),
    .parity_type (parity_type),
    .stop2       (stop2),
    .tx_out      (out2),
    .busy        (busy2),
    .done        (done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every fourth cycle, updated 1 ns after the edge.
  initial begin : tick_gen
    int div;
    div = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = tick_en && (div == 3);
      div = (div == 3) ? 0 : div + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  // Expected line levels, one per bit period, first bit in seq[11].
  function automatic void model_frame(input logic [7:0] d, input logic [1:0] pt,
                                      input logic s2, output logic [11:0] seq,
                                      output int len);
    int ones;
    bit bits[$];
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pt == 2'b10) bits.push_back(ones % 2 == 1);
    else if (pt == 2'b01) bits.push_back(ones % 2 == 0);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    len = bits.size();
    seq = '0;
    for (int i = 0; i < len; i++) seq[11-i] = bits[i];
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 200 && !tx_ready_s; i++) at_drive();
    check("ready_timeout", {31'd0, tx_ready_s}, 32'd1);
  endtask

  // Hands one frame to the selected instance, then scrambles the inputs.
  task automatic send(input logic [7:0] d, input logic [1:0] pt, input logic s2);
    wait_ready();
    data_in = d;
    parity_type = pt;
    stop2 = s2;
    tx_valid = 1'b1;
    at_drive();
    tx_valid = 1'b0;
    data_in = 8'($urandom);
    parity_type = 2'($urandom);
    stop2 = 1'($urandom);
  endtask

  // Samples the line on each tick after the SYNC tick until done; then the ready level.
  task automatic capture(output logic [11:0] seq, output int len, output int ndone,
                         output logic rdy);
    int cycles;
    bit first;
    seq = '0;
    len = 0;
    ndone = 0;
    first = 1'b1;
    cycles = 0;
    while (ndone == 0 && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (baud_tick) begin
        if (first) first = 1'b0;
        else begin
          if (len < 12) seq[11-len] = tx_out_s;
          len++;
        end
      end
      if (done_s) ndone++;
    end
    @(negedge clk);
    rdy = tx_ready_s;
    if (done_s) ndone++;
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [1:0]  pt;
    logic        s2;
    logic [11:0] seq;
    int          len;
  } vec_t;

  initial begin : main
    vec_t        vecs[4];
    logic [11:0] seq, exp_seq;
    int          len, exp_len, ndone, cnt, ticks;
    logic        rdy;
    logic [7:0]  d;
    logic [1:0]  pt;
    logic        s2;

    n_pass = 0;
    n_total = 0;
    vecs[0] = '{8'h17, 2'b10, 1'b0, 12'b0111_0100_0010, 11};
    vecs[1] = '{8'h07, 2'b01, 1'b1, 12'b0111_0000_0011, 12};
    vecs[2] = '{8'hA9, 2'b00, 1'b0, 12'b0100_1010_1100, 10};
    vecs[3] = '{8'hA9, 2'b11, 1'b0, 12'b0100_1010_1100, 10};

    reset = 1'b1;
    tx_valid = 1'b0;
    sel = 1'b0;
    data_in = 8'h00;
    parity_type = 2'b00;
    stop2 = 1'b0;
    tick_en = 1'b1;
    repeat (3) at_drive();
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx_out", {31'd0, tx_out_s}, 32'd1);
    check("rst_ready", {31'd0, tx_ready_s}, 32'd1);
    check("rst_busy", {31'd0, busy_s}, 32'd0);
    check("rst_done", {31'd0, done_s}, 32'd0);

    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].pt, vecs[i].s2);
      capture(seq, len, ndone, rdy);
      check($sformatf("vec%0d_seq", i), {20'd0, seq}, {20'd0, vecs[i].seq});
      check($sformatf("vec%0d_len", i), len, vecs[i].len);
      check($sformatf("vec%0d_done", i), ndone, 1);
      check($sformatf("vec%0d_ready", i), {31'd0, rdy}, 32'd1);
    end

    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      pt = 2'($urandom);
      s2 = 1'($urandom);
      model_frame(d, pt, s2, exp_seq, exp_len);
      send(d, pt, s2);
      capture(seq, len, ndone, rdy);
      check($sformatf("rnd%0d_seq d=%0h", n, d), {20'd0, seq}, {20'd0, exp_seq});
      check($sformatf("rnd%0d_len", n), len, exp_len);
      check($sformatf("rnd%0d_done", n), ndone, 1);
      check($sformatf("rnd%0d_ready", n), {31'd0, rdy}, 32'd1);
    end

    // Request lands on a tick cycle: that tick must not advance past SYNC.
    wait_ready();
    for (int i = 0; i < 8 && !baud_tick; i++) at_drive();
    data_in = 8'h55;
    parity_type = 2'b00;
    stop2 = 1'b0;
    tx_valid = 1'b1;
    at_drive();
    tx_valid = 1'b0;
    @(negedge clk);
    check("same_tick_busy", {31'd0, busy_s}, 32'd1);
    check("same_tick_sync_high", {31'd0, tx_out_s}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 20 && tx_out_s; i++) begin
      @(negedge clk);
      cnt++;
    end
    check("same_tick_start_delay", cnt, 4);
    wait_ready();

    // Reset during data bit 4 aborts the frame with no done pulse.
    send(8'hC3, 2'b10, 1'b0);
    ticks = 0;
    ndone = 0;
    for (int i = 0; i < 100 && ticks < 6; i++) begin
      @(negedge clk);
      if (baud_tick) ticks++;
      if (done_s) ndone++;
    end
    @(negedge clk);
    check("abort_bit4_level", {31'd0, tx_out_s}, 32'd0);
    at_drive();
    reset = 1'b1;
    @(negedge clk);
    if (done_s) ndone++;
    at_drive();
    reset = 1'b0;
    @(negedge clk);
    if (done_s) ndone++;
    check("abort_tx_out", {31'd0, tx_out_s}, 32'd1);
    check("abort_ready", {31'd0, tx_ready_s}, 32'd1);
    check("abort_busy", {31'd0, busy_s}, 32'd0);
    check("abort_no_done", ndone, 0);
    send(8'h17, 2'b10, 1'b0);
    capture(seq, len, ndone, rdy);
    check("after_abort_seq", {20'd0, seq}, {20'd0, vecs[0].seq});
    check("after_abort_done", ndone, 1);

    // Reset wins over a simultaneous request and tick.
    wait_ready();
    for (int i = 0; i < 8 && !baud_tick; i++) at_drive();
    reset = 1'b1;
    tx_valid = 1'b1;
    at_drive();
    reset = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    check("rst_prio_ready", {31'd0, tx_ready_s}, 32'd1);
    check("rst_prio_busy", {31'd0, busy_s}, 32'd0);

    // Back-to-back frames through the FRAME_GAP=2 instance with tx_valid held high.
    sel = 1'b1;
    wait_ready();
    data_in = 8'hAF;
    parity_type = 2'b10;
    stop2 = 1'b0;
    tx_valid = 1'b1;
    at_drive();
    data_in = 8'hBD;
    capture(seq, len, ndone, rdy);
    model_frame(8'hAF, 2'b10, 1'b0, exp_seq, exp_len);
    check("gap_f1_seq", {20'd0, seq}, {20'd0, exp_seq});
    check("gap_f1_done", ndone, 1);
    check("gap_f1_ready_low", {31'd0, rdy}, 32'd0);
    cnt = 0;
    seq = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (baud_tick) begin
        if (!tx_out_s) break;
        cnt++;
      end
    end
    check("gap_high_ticks", cnt, 3);
    len = 1;
    for (int i = 0; i < 100 && len < 11; i++) begin
      @(negedge clk);
      if (baud_tick) begin
        seq[11-len] = tx_out_s;
        len++;
      end
    end
    at_drive();
    tx_valid = 1'b0;
    model_frame(8'hBD, 2'b10, 1'b0, exp_seq, exp_len);
    check("gap_f2_seq", {20'd0, seq}, {20'd0, exp_seq});
    wait_ready();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
